// File: rtl/rf_pkg.sv
// Shared register-file constants used by the writeback scheduler, the
// register file and the decoder.
package rf_pkg;
  localparam int AW    = 5;
  localparam int NREGS = 32;
  localparam int XLEN  = 32;
  localparam logic [AW-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
//   req       : request vector, one bit per requester
//   grant     : one-hot grant, zero when no request is pending
//   grant_idx : index of the granted requester (valid when |grant)
// The search starts at the priority pointer. After a grant the pointer moves
// to the requester just after the winner. With no grant it holds.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_sched.sv
// Writeback scheduler and scoreboard for the 32x32 register file.
//   iss_valid/iss_rd     : decode reserves a destination register
//   wb_valid/wb_rd/wb_data, wb_ready : requester handshakes, one-hot grant
//   rf_we/rf_rd_addr/rf_rd_data      : registered register-file write port
//   rs1/rs2_addr -> rs1/rs2_busy     : RAW hazard queries for decode
//   busy_vec             : pending-write scoreboard (bit 0 always 0)
//   wb_err/err_clr       : sticky flag for writes to unreserved registers
module rf_wb_sched #(
  parameter int NREQ = 2,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     iss_valid,
  input  logic [AW-1:0]            iss_rd,
  input  logic [NREQ-1:0]          wb_valid,
  input  logic [NREQ*AW-1:0]       wb_rd,
  input  logic [NREQ*XLEN-1:0]     wb_data,
  output logic [NREQ-1:0]          wb_ready,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_rd_addr,
  output logic [XLEN-1:0]          rf_rd_data,
  input  logic [AW-1:0]            rs1_addr,
  input  logic [AW-1:0]            rs2_addr,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  output logic [rf_pkg::NREGS-1:0] busy_vec,
  output logic                     wb_err,
  input  logic                     err_clr
);
  import rf_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    grant_idx;
  logic             g_valid;
  logic [AW-1:0]    g_rd;
  logic [XLEN-1:0]  g_data;
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_next;
  logic             err_set;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (wb_valid),
    .grant     (wb_ready),
    .grant_idx (grant_idx)
  );

  assign g_valid = |wb_ready;

  always_comb begin
    g_rd   = '0;
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (wb_ready[i]) begin
        g_rd   = wb_rd[i*AW +: AW];
        g_data = wb_data[i*XLEN +: XLEN];
      end
    end
  end

  // Clear on the actual port write, then set, so a same-cycle reservation
  // (the younger one) survives.
  always_comb begin
    busy_next = busy_q;
    if (rf_we)
      busy_next[rf_rd_addr] = 1'b0;
    if (iss_valid)
      busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  assign err_set = g_valid && (g_rd != REG_ZERO) && !busy_q[g_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_rd_addr <= '0;
      rf_rd_data <= '0;
      busy_q     <= '0;
      wb_err     <= 1'b0;
    end else begin
      rf_we <= g_valid && (g_rd != REG_ZERO);
      if (g_valid) begin
        rf_rd_addr <= g_rd;
        rf_rd_data <= g_data;
      end
      busy_q <= busy_next;
      wb_err <= err_set | (wb_err & ~err_clr);
    end
  end

  assign busy_vec = busy_q;

  // Granted and staged writes also count as busy, so a write to a register
  // whose reservation was never made still blocks readers until it lands.
  assign rs1_busy = (rs1_addr != REG_ZERO) &&
                    (busy_q[rs1_addr] || (g_valid && g_rd == rs1_addr) ||
                     (rf_we && rf_rd_addr == rs1_addr));
  assign rs2_busy = (rs2_addr != REG_ZERO) &&
                    (busy_q[rs2_addr] || (g_valid && g_rd == rs2_addr) ||
                     (rf_we && rf_rd_addr == rs2_addr));

endmodule

// File: tb/tb_rf_wb_sched.sv
module tb_rf_wb_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic [1:0]  wb_valid = '0;
  logic [9:0]  wb_rd = '0;
  logic [63:0] wb_data = '0;
  logic [1:0]  wb_ready;
  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        rs1_busy, rs2_busy;
  logic [31:0] busy_vec;
  logic        wb_err;
  logic        err_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  rf_wb_sched #(.NREQ(2), .XLEN(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .busy_vec(busy_vec), .wb_err(wb_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // Every port write is checked against the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      logic [36:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL port_write: got addr=%0d data=%h want no write", rf_rd_addr, rf_rd_data);
      end else begin
        e = exp_q.pop_front();
        if ({rf_rd_addr, rf_rd_data} !== e) begin
          n_err++;
          $display("FAIL port_write: got addr=%0d data=%h want addr=%0d data=%h",
                   rf_rd_addr, rf_rd_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wb_valid = 2'b11;
    wb_rd = '0;
    repeat (2) tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    n_cmp++; if (busy_vec !== 32'h0) begin n_err++; $display("FAIL reset_busy: got %h want 0", busy_vec); end
    n_cmp++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", wb_err); end
    n_cmp++; if (rf_rd_addr !== 5'd0 || rf_rd_data !== 32'h0) begin
      n_err++; $display("FAIL reset_port: got %0d/%h want 0/0", rf_rd_addr, rf_rd_data); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (wb_ready !== 2'b01) begin n_err++; $display("FAIL reset_first_grant: got %b want 01", wb_ready); end
    wb_valid = 2'b00;
    #1;
    n_cmp++; if (wb_ready !== 2'b00) begin n_err++; $display("FAIL ready_idle: got %b want 00", wb_ready); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0]  eg;
    logic [4:0]  ea;
    logic [31:0] ed;
    iss_valid = 1'b1; iss_rd = 5'd3; tick();
    iss_rd = 5'd4; tick();
    iss_valid = 1'b0;
    n_cmp++; if (busy_vec[4:3] !== 2'b11) begin n_err++; $display("FAIL rr_reserve: got %b want 11", busy_vec[4:3]); end
    wb_rd = {5'd4, 5'd3};
    wb_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wb_data = {32'hB000_0000 + 32'(k), 32'hA000_0000 + 32'(k)};
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      ea = (k % 2 == 0) ? 5'd3 : 5'd4;
      ed = (k % 2 == 0) ? 32'hA000_0000 + 32'(k) : 32'hB000_0000 + 32'(k);
      #1;
      n_cmp++; if (wb_ready !== eg) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", k, wb_ready, eg); end
      exp_q.push_back({ea, ed});
      tick();
      if (k == 3) wb_valid = 2'b00;
      n_cmp++; if (rf_rd_addr !== ea) begin n_err++; $display("FAIL rr_addr%0d: got %0d want %0d", k, rf_rd_addr, ea); end
    end
    tick();
    // second writes to 3 and 4 had no reservation left
    n_cmp++; if (wb_err !== 1'b1) begin n_err++; $display("FAIL rr_err: got %b want 1", wb_err); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_cmp++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL rr_err_clr: got %b want 0", wb_err); end
  endtask

  task automatic test_scoreboard();
    iss_valid = 1'b1; iss_rd = 5'd7; tick();
    iss_valid = 1'b0;
    rs1_addr = 5'd7;
    #1;
    n_cmp++; if (busy_vec[7] !== 1'b1) begin n_err++; $display("FAIL sb_set: got %b want 1", busy_vec[7]); end
    n_cmp++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL sb_rs1_n1: got %b want 1", rs1_busy); end
    tick();
    tick();
    wb_valid = 2'b01; wb_rd[4:0] = 5'd7; wb_data[31:0] = 32'hDEADBEEF;
    #1;
    n_cmp++; if (wb_ready !== 2'b01) begin n_err++; $display("FAIL sb_grant: got %b want 01", wb_ready); end
    exp_q.push_back({5'd7, 32'hDEADBEEF});
    tick();
    wb_valid = 2'b00;
    n_cmp++; if (rf_we !== 1'b1 || rf_rd_addr !== 5'd7) begin
      n_err++; $display("FAIL sb_write: got we=%b addr=%0d want we=1 addr=7", rf_we, rf_rd_addr); end
    n_cmp++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL sb_rs1_n4: got %b want 1", rs1_busy); end
    tick();
    n_cmp++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL sb_rs1_n5: got %b want 0", rs1_busy); end
    n_cmp++; if (busy_vec[7] !== 1'b0) begin n_err++; $display("FAIL sb_clear: got %b want 0", busy_vec[7]); end
    rs1_addr = 5'd0;
  endtask

  task automatic test_set_clear();
    iss_valid = 1'b1; iss_rd = 5'd9; tick();
    iss_valid = 1'b0;
    wb_valid = 2'b10; wb_rd[9:5] = 5'd9; wb_data[63:32] = 32'h0000_0099;
    #1;
    n_cmp++; if (wb_ready !== 2'b10) begin n_err++; $display("FAIL sc_grant: got %b want 10", wb_ready); end
    exp_q.push_back({5'd9, 32'h0000_0099});
    tick();
    wb_valid = 2'b00;
    iss_valid = 1'b1; iss_rd = 5'd9;
    rs2_addr = 5'd9;
    tick();
    iss_valid = 1'b0;
    n_cmp++; if (busy_vec[9] !== 1'b1) begin n_err++; $display("FAIL sc_busy9: got %b want 1", busy_vec[9]); end
    n_cmp++; if (rs2_busy !== 1'b1) begin n_err++; $display("FAIL sc_rs2: got %b want 1", rs2_busy); end
    n_cmp++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL sc_rs1_x0: got %b want 0", rs1_busy); end
    n_cmp++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL sc_err: got %b want 0", wb_err); end
    rs2_addr = 5'd0;
  endtask

  task automatic test_x0();
    wb_valid = 2'b10; wb_rd[9:5] = 5'd0; wb_data[63:32] = 32'h0000_1234;
    #1;
    n_cmp++; if (wb_ready !== 2'b10) begin n_err++; $display("FAIL x0_grant: got %b want 10", wb_ready); end
    tick();
    wb_valid = 2'b00;
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL x0_we: got %b want 0", rf_we); end
    n_cmp++; if (rf_rd_data !== 32'h0000_1234 || rf_rd_addr !== 5'd0) begin
      n_err++; $display("FAIL x0_stage: got %0d/%h want 0/00001234", rf_rd_addr, rf_rd_data); end
    n_cmp++; if (busy_vec[0] !== 1'b0) begin n_err++; $display("FAIL x0_busy: got %b want 0", busy_vec[0]); end
    n_cmp++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL x0_err: got %b want 0", wb_err); end
  endtask

  task automatic test_error_reset();
    wb_valid = 2'b01; wb_rd[4:0] = 5'd12; wb_data[31:0] = 32'hCAFE_0012;
    exp_q.push_back({5'd12, 32'hCAFE_0012});
    tick();
    wb_valid = 2'b00;
    n_cmp++; if (wb_err !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", wb_err); end
    n_cmp++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL err_write: got %b want 1", rf_we); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_cmp++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL err_clr: got %b want 0", wb_err); end
    iss_valid = 1'b1; iss_rd = 5'd5; tick();
    iss_valid = 1'b0;
    wb_valid = 2'b01; wb_rd[4:0] = 5'd5; wb_data[31:0] = 32'h0000_0055;
    tick();
    wb_valid = 2'b00;
    n_cmp++; if (rf_we !== 1'b1 || busy_vec[5] !== 1'b1) begin
      n_err++; $display("FAIL pre_reset: got we=%b busy5=%b want 1/1", rf_we, busy_vec[5]); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL midreset_we: got %b want 0", rf_we); end
    n_cmp++; if (busy_vec !== 32'h0) begin n_err++; $display("FAIL midreset_busy: got %h want 0", busy_vec); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_scoreboard();
    test_set_clear();
    test_x0();
    test_error_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL pending_writes: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wb_sched.md
# rf_wb_sched

Writeback scheduler and scoreboard for the 32×32 register file (x0 hardwired to zero, one synchronous write port, two combinational read ports). It shares the single write port among NREQ writeback requesters (ALU, LSU, ...) using round-robin valid/ready arbitration, and drives the port from a registered stage. It also tracks which destination registers have an in-flight write, so decode can stall on RAW hazards.

## Interface
- NREQ, 2: number of writeback requesters, 2..4
- XLEN, 32: data width
- AW, 5: register address width (32 registers)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- iss_valid  in  1  decode issues an instruction that writes iss_rd
- iss_rd  in  AW  destination to reserve
- wb_valid  in  NREQ  requester i holds a writeback
- wb_rd  in  NREQ*AW  requester i destination, slice i
- wb_data  in  NREQ*XLEN  requester i data, slice i
- wb_ready  out  NREQ  one-hot grant; transfer when valid&ready
- rf_we  out  1  register-file write enable
- rf_rd_addr  out  AW  register-file write address
- rf_rd_data  out  XLEN  register-file write data
- rs1_addr, rs2_addr  in  AW each  decode source queries
- rs1_busy, rs2_busy  out  1 each  source has a pending write
- busy_vec  out  32  scoreboard, bit 0 always 0
- wb_err  out  1  sticky: writeback to a non-reserved register
- err_clr  in  1  clears wb_err

## Operation
- Arbitration: priority pointer `ptr` (0..NREQ-1). Grant the first valid requester searching ptr, ptr+1, … modulo NREQ.
  - wb_ready is combinational: one-hot, at most one bit set, 0 when no wb_valid is set.
  - After a grant to i, ptr <= (i+1) mod NREQ. ptr holds when there is no grant.
- Output stage: on a grant, register rf_rd_addr <= wb_rd[i] and rf_rd_data <= wb_data[i], and set rf_we <= 1 if wb_rd[i] != 0, else 0.
  - With no grant, rf_we <= 0. Address and data hold.
  - The stage never stalls; one transfer per cycle maximum.
- Scoreboard, per register r != 0, at each edge:
  - Set when iss_valid and iss_rd == r.
  - Clear when rf_we and rf_rd_addr == r (the actual port write).
  - Set and clear in the same cycle: set wins, because the new reservation is younger.
  - iss_rd == 0 is ignored. busy_vec[0] is constant 0.
- rsN_busy = busy_vec[rsN_addr], or 1 when a granted in-flight write targets rsN_addr.
  - This lookahead prevents the one-cycle gap between grant and port write, so no stale read occurs.
  - rsN_addr == 0 always gives 0.
- Error: a grant with wb_rd != 0 whose busy bit is 0 sets wb_err. err_clr clears it, and set wins over clear. The write still proceeds.

## Timing
- Reset values: rf_we=0, rf_rd_addr=0, rf_rd_data=0, busy_vec=0, wb_err=0, ptr=0. wb_ready follows its inputs (0 when wb_valid=0).
- Writeback latency: handshake in cycle N, rf_we high in N+1, register file updated at the end of N+1, busy bit cleared at the same edge.
- A read of rd is correct from cycle N+2. rsN_busy is high through N+1.
- Issue in cycle N makes busy visible from N+1.
- Reset asserted mid-operation: all state clears immediately, and a pending rf_we is dropped; that write is lost by design.
- Requesters must hold wb_valid, wb_rd and wb_data stable until wb_ready.

## Structure
- Shared package rf_pkg: constants AW=5, NREGS=32, XLEN=32, and REG_ZERO=5'd0. These are also used by the register file and the decoder.
- Sub-module rr_arbiter (NREQ parameter): request vector in, one-hot grant out, internal pointer updated on grant. It is reusable for the memory-port arbiter.
- Everything else (scoreboard, output register, error flag) lives in rf_wb_sched.

## Test plan
- Reset: hold rst_n=0 with wb_valid=2'b11 → rf_we=0, busy_vec=0, wb_err=0. Release reset; first grant goes to requester 0 (wb_ready=2'b01).
- Round-robin: keep both requesters valid for 4 cycles, rd=3 and rd=4 (pre-issued) → grants alternate 01,10,01,10, and rf_rd_addr follows 3,4,3,4 one cycle later.
- Scoreboard: issue rd=7 at N → busy_vec[7]=1 from N+1. wb rd=7, data=0xDEADBEEF at N+3 → rf_we=1, rf_rd_addr=7 at N+4; rs1_busy for rs1=7 is 1 through N+4 and 0 at N+5.
- Simultaneous set and clear: write of rd=9 lands while iss_rd=9 in the same cycle → busy_vec[9] stays 1.
- x0: wb_rd=0, data=0x1234 → wb_ready=1 and the transfer completes, but rf_we stays 0; busy_vec[0]=0; no wb_err.
- Error and reset: writeback to rd=12 with no reservation → wb_err=1, write still performed; err_clr=1 → 0. Assert rst_n low in the cycle after a grant → rf_we=0 immediately and busy_vec=0.
